// File: rtl/alu_uart_host.sv
// -----------------------------------------------------------------------------
// alu_uart_host
//
// Host-side initiator for the UART-attached ALU command protocol. A command
// (a, b, op) taken on start is pushed into the UART TX FIFO as three bytes in
// the order A, B, OP. The block then waits, bounded by an optional timeout,
// for the single result byte in the UART RX FIFO and reports it with a
// one-cycle done pulse.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   reset     synchronous, active-high reset
//   start     command request, sampled only while idle
//   a_in      operand A (signed)
//   b_in      operand B (signed)
//   op_in     opcode
//   busy      high whenever a transaction is in progress (not idle)
//   done      one-cycle pulse when a transaction ends
//   timeout   qualifies done: 1 = no reply arrived; holds until next start
//   result    reply byte (signed), 0 on timeout; holds until next done
//   wr_uart   TX FIFO push strobe
//   w_data    TX FIFO write data, 0 whenever wr_uart is low
//   tx_full   TX FIFO full
//   rd_uart   RX FIFO pop strobe
//   r_data    RX FIFO head data, valid while rx_empty is low
//   rx_empty  RX FIFO empty
// -----------------------------------------------------------------------------
module alu_uart_host #(
  parameter int REG_SIZE       = 8,       // operand/opcode/result width; must be 8
  parameter int TIMEOUT_CYCLES = 100000,  // reply wait budget in cycles, 0 = wait forever
  parameter int TO_W           = 24       // timeout counter width, 2**TO_W > TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [REG_SIZE-1:0] a_in,
  input  logic signed [REG_SIZE-1:0] b_in,
  input  logic        [REG_SIZE-1:0] op_in,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic signed [REG_SIZE-1:0] result,
  output logic                       wr_uart,
  output logic        [7:0]          w_data,
  input  logic                       tx_full,
  output logic                       rd_uart,
  input  logic        [7:0]          r_data,
  input  logic                       rx_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_SEND_OP,
    S_WAIT_RES,
    S_DONE
  } state_t;

  // Last counter value before the reply wait expires. With the timeout
  // disabled the comparison is never enabled and the counter simply wraps.
  localparam bit            LP_TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] LP_LAST =
    TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t                     r_state;
  state_t                     w_next;
  logic signed [REG_SIZE-1:0] r_a;
  logic signed [REG_SIZE-1:0] r_b;
  logic        [REG_SIZE-1:0] r_op;
  logic signed [REG_SIZE-1:0] r_result;
  logic                       r_timeout;
  logic        [TO_W-1:0]     r_cnt;
  logic                       w_expire;

  assign w_expire = LP_TO_EN && (r_cnt == LP_LAST) && rx_empty;

  // Status decoded from the registered state only, so it is glitch-free.
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign timeout = r_timeout;
  assign result  = r_result;

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned; otherwise synthesis infers latches.
  always_comb begin
    w_next  = r_state;
    wr_uart = 1'b0;
    rd_uart = 1'b0;
    w_data  = 8'h00;
    case (r_state)
      S_IDLE: begin
        // Any byte seen while idle is stale (e.g. a late reply); drop it.
        rd_uart = ~rx_empty;
        if (start) w_next = S_SEND_A;
      end
      S_SEND_A: begin
        wr_uart = ~tx_full;
        if (!tx_full) begin
          w_data = 8'(r_a);
          w_next = S_SEND_B;
        end
      end
      S_SEND_B: begin
        wr_uart = ~tx_full;
        if (!tx_full) begin
          w_data = 8'(r_b);
          w_next = S_SEND_OP;
        end
      end
      S_SEND_OP: begin
        wr_uart = ~tx_full;
        if (!tx_full) begin
          w_data = 8'(r_op);
          w_next = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        rd_uart = ~rx_empty;
        // A byte present on the expiry cycle is taken, not the timeout.
        if (!rx_empty || w_expire) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // FIFO strobes must stay quiet while reset is held, whatever the state.
    if (reset) begin
      wr_uart = 1'b0;
      rd_uart = 1'b0;
      w_data  = 8'h00;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= a_in;
            r_b       <= b_in;
            r_op      <= op_in;
            r_timeout <= 1'b0;
          end
        end
        S_SEND_OP: begin
          if (!tx_full) r_cnt <= '0;
        end
        S_WAIT_RES: begin
          if (!rx_empty) begin
            r_result  <= REG_SIZE'(r_data);
            r_timeout <= 1'b0;
          end else if (w_expire) begin
            r_result  <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_host.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_host
//
// Self-checking bench for alu_uart_host (TIMEOUT_CYCLES = 10). The bench plays
// both UART FIFOs: it logs every byte pushed into the TX side, serves reply
// bytes from a queue on the RX side, and predicts each transaction from the
// protocol rules: the three command bytes go out on the first three cycles
// where the TX FIFO is not full, the reply (if any) is read on the cycle it
// appears, silence ends after ten waiting cycles, and done follows one cycle
// later. Cycle 0 is the cycle in which start is sampled.
// -----------------------------------------------------------------------------
module tb_alu_uart_host;

  localparam int TO = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic signed [7:0] a_in;
  logic signed [7:0] b_in;
  logic        [7:0] op_in;
  logic              busy;
  logic              done;
  logic              timeout;
  logic signed [7:0] result;
  logic              wr_uart;
  logic        [7:0] w_data;
  logic              tx_full;
  logic              rd_uart;
  logic        [7:0] r_data;
  logic              rx_empty;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] rxq[$];

  // Outputs of the cycle most recently completed by step().
  logic       s_busy, s_done, s_to, s_wr, s_rd, s_full;
  logic [7:0] s_res, s_wd;

  alu_uart_host #(
    .REG_SIZE      (8),
    .TIMEOUT_CYCLES(TO),
    .TO_W          (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .op_in   (op_in),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .result  (result),
    .wr_uart (wr_uart),
    .w_data  (w_data),
    .tx_full (tx_full),
    .rd_uart (rd_uart),
    .r_data  (r_data),
    .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  endtask

  // Sample the current cycle's outputs mid-cycle, let the edge happen, then
  // apply the FIFO side effects of that edge and move to the next cycle.
  task automatic step();
    @(negedge clk);
    s_busy = busy;  s_done = done;  s_to = timeout; s_res = result;
    s_wr   = wr_uart; s_wd = w_data; s_rd = rd_uart; s_full = tx_full;
    @(posedge clk);
    #1;
    if (s_rd && rxq.size() > 0) void'(rxq.pop_front());
    update_rx();
    cyc++;
  endtask

  // One full command. full_mask bit c is tx_full during cycle c; delay < 0
  // means the responder stays silent, otherwise the reply byte appears in the
  // RX FIFO 'delay' cycles after the reply wait begins. A second start pulse
  // is raised in cycle again_cycle (0 = none) and must be ignored.
  task automatic run_txn(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [63:0] full_mask,
                         input int delay, input logic [7:0] reply, input int again_cycle);
    int         exp_wc[3];
    int         n;
    int         w3, exp_done, exp_rd;
    logic [7:0] exp_res, exp_byte[3];
    logic       exp_to;
    int         wc[3];
    logic [7:0] wb[3];
    int         nwr, nrd, rd_at, got_done, bad_wr, c;
    logic       d_busy, d_to;
    logic [7:0] d_res;

    // Reference model.
    n = 0;
    for (int i = 1; i < 64; i++)
      if (!full_mask[i] && n < 3) begin exp_wc[n] = i; n++; end
    w3 = exp_wc[2];
    exp_byte[0] = a; exp_byte[1] = b; exp_byte[2] = op;
    if (delay < 0) begin
      exp_rd = -1; exp_done = w3 + 1 + TO; exp_res = 8'h00; exp_to = 1'b1;
    end else begin
      exp_rd = w3 + 1 + delay; exp_done = exp_rd + 1; exp_res = reply; exp_to = 1'b0;
    end

    nwr = 0; nrd = 0; rd_at = -1; got_done = -1; bad_wr = 0;
    d_busy = 1'b0; d_to = 1'bx; d_res = 8'hxx;
    wc = '{-1, -1, -1};
    wb = '{8'h00, 8'h00, 8'h00};

    cyc = 0;
    start = 1'b1; a_in = a; b_in = b; op_in = op; tx_full = full_mask[0];
    step();
    while (got_done < 0 && cyc < 200) begin
      c = cyc;
      tx_full = (c < 64) ? full_mask[c] : 1'b0;
      start   = (c == again_cycle);
      // Operands change under the DUT; only the latched copies may be sent.
      a_in = 8'($urandom); b_in = 8'($urandom); op_in = 8'($urandom);
      if (delay >= 0 && c == exp_rd) begin
        rxq.push_back(reply);
        update_rx();
      end
      step();
      if (s_wr) begin
        if (s_full) bad_wr++;
        if (nwr < 3) begin wb[nwr] = s_wd; wc[nwr] = c; end
        nwr++;
      end
      if (s_rd) begin nrd++; rd_at = c; end
      if (s_done) begin got_done = c; d_busy = s_busy; d_res = s_res; d_to = s_to; end
    end
    start = 1'b0; tx_full = 1'b0;

    check({name, " done_cycle"}, got_done, exp_done);
    check({name, " tx_count"}, nwr, 3);
    check({name, " wr_while_full"}, bad_wr, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s tx_byte%0d", name, i), {24'h0, wb[i]}, {24'h0, exp_byte[i]});
      check($sformatf("%s tx_cycle%0d", name, i), wc[i], exp_wc[i]);
    end
    check({name, " rd_count"}, nrd, (delay < 0) ? 0 : 1);
    check({name, " rd_cycle"}, rd_at, exp_rd);
    check({name, " busy_in_done"}, {31'h0, d_busy}, 32'h1);
    check({name, " result"}, {24'h0, d_res}, {24'h0, exp_res});
    check({name, " timeout"}, {31'h0, d_to}, {31'h0, exp_to});

    step();
    check({name, " busy_after"}, {31'h0, s_busy}, 32'h0);
    check({name, " done_single"}, {31'h0, s_done}, 32'h0);
    check({name, " result_hold"}, {24'h0, s_res}, {24'h0, exp_res});
    check({name, " timeout_hold"}, {31'h0, s_to}, {31'h0, exp_to});
  endtask

  initial begin
    int         n_rd, n_done;
    logic [63:0] m;
    int         d;

    reset = 1'b1; start = 1'b0; tx_full = 1'b0;
    a_in = '0; b_in = '0; op_in = '0;
    update_rx();

    // Reset state.
    step();
    step();
    reset = 1'b0;
    step();
    check("reset busy", {31'h0, s_busy}, 32'h0);
    check("reset done", {31'h0, s_done}, 32'h0);
    check("reset result", {24'h0, s_res}, 32'h0);
    check("reset timeout", {31'h0, s_to}, 32'h0);
    check("reset wr_uart", {31'h0, s_wr}, 32'h0);
    check("reset rd_uart", {31'h0, s_rd}, 32'h0);

    // Nominal command, immediate reply.
    run_txn("nominal", 8'd5, 8'hFD, 8'h20, 64'h0, 0, 8'h02, 0);

    // TX FIFO full during cycles 2..6, stalling the B byte.
    run_txn("backpressure", 8'h5A, 8'hFD, 8'h20, 64'h7C, 0, 8'h33, 0);

    // Silent responder, then a replied command clears timeout.
    run_txn("timeout", 8'h01, 8'h02, 8'h03, 64'h0, -1, 8'h00, 0);
    run_txn("after_timeout", 8'h10, 8'h20, 8'h00, 64'h0, 3, 8'hC4, 0);

    // Reply appears exactly on the expiry cycle.
    run_txn("race", 8'h0F, 8'hF0, 8'h01, 64'h0, TO - 1, 8'h7F, 0);

    // Stale bytes while idle are flushed without a done pulse.
    rxq.push_back(8'hEE);
    rxq.push_back(8'h99);
    update_rx();
    n_rd = 0; n_done = 0;
    repeat (6) begin
      step();
      if (s_rd) n_rd++;
      if (s_done) n_done++;
    end
    check("flush rd_count", n_rd, 2);
    check("flush no_done", n_done, 0);
    check("flush drained", rxq.size(), 0);

    // Second start during SEND_A, and another during DONE, are ignored.
    run_txn("restart_send", 8'h44, 8'h55, 8'h66, 64'h0, 1, 8'h21, 1);
    run_txn("restart_done", 8'h47, 8'h58, 8'h69, 64'h0, 0, 8'h12, 5);

    // Reset in the middle of the reply wait.
    run_txn("pre_reset", 8'h11, 8'h22, 8'h33, 64'h0, 0, 8'hA5, 0);
    cyc = 0;
    start = 1'b1; a_in = 8'h01; b_in = 8'h02; op_in = 8'h03; tx_full = 1'b0;
    step();
    start = 1'b0;
    while (cyc < 6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("midreset busy", {31'h0, s_busy}, 32'h0);
    check("midreset result", {24'h0, s_res}, 32'h0);
    check("midreset timeout", {31'h0, s_to}, 32'h0);
    n_done = 0;
    repeat (15) begin
      step();
      if (s_done) n_done++;
    end
    check("midreset no_done", n_done, 0);
    run_txn("post_reset", 8'd5, 8'hFD, 8'h20, 64'h0, 0, 8'h02, 0);

    // Randomized commands, stalls, reply delays and stray start pulses.
    for (int t = 0; t < 12; t++) begin
      m = '0;
      for (int i = 1; i < 40; i++) m[i] = ($urandom_range(0, 9) < 3);
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run_txn($sformatf("rand%0d", t), 8'($urandom), 8'($urandom), 8'($urandom),
              m, d, 8'($urandom), int'($urandom_range(0, 8)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_uart_host.md
Name: alu_uart_host

Overview:
- Host-side initiator for the UART-attached ALU command protocol: it is the other end of the device that reads operand A, operand B and opcode bytes from its RX FIFO and returns one result byte.
- Takes a command (a, b, op) from local logic and pushes three bytes into the UART TX FIFO in order A, B, OP.
- Waits for the single result byte in the UART RX FIFO, bounded by a timeout, then returns it with a done pulse.
- Sits between a local controller/testbench sequencer and the UART TX/RX FIFO pair.

Parameters:
- REG_SIZE, 8, width of operands, opcode and result. Bytes on the UART are 8 bits; REG_SIZE must be 8.
- TIMEOUT_CYCLES, 100000, clk cycles to wait for the result byte. A value of 0 disables the timeout.
- TO_W, 24, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  command request; sampled only in IDLE
- a_in  input  REG_SIZE signed  operand A
- b_in  input  REG_SIZE signed  operand B
- op_in  input  REG_SIZE  opcode
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the transaction ends
- timeout  output  1  qualifies done: 1 = no reply; holds until next start
- result  output  REG_SIZE signed  reply byte; holds until next done
- wr_uart  output  1  TX FIFO push strobe
- w_data  output  8  TX FIFO write data
- tx_full  input  1  TX FIFO full
- rd_uart  output  1  RX FIFO pop strobe
- r_data  input  8  RX FIFO head data, valid when rx_empty=0
- rx_empty  input  1  RX FIFO empty

Behaviour:
- FIFO contract: w_data is written on a clk edge where wr_uart=1. r_data is the FIFO head and is consumed on a clk edge where rd_uart=1.
- Reset (synchronous, active-high) forces: state=IDLE, a/b/op latches=0, result=0, timeout=0, done=0, counter=0. wr_uart, rd_uart and busy are 0 during and after reset.
- States: IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE.
- IDLE:
  - start=1: latch a_in, b_in, op_in; clear timeout; next state SEND_A.
  - rx_empty=0: rd_uart=1 to flush a stale byte; the byte is discarded. Flush and start may occur in the same cycle; both take effect.
- SEND_A / SEND_B / SEND_OP:
  - w_data = latched A / B / OP, combinational from state.
  - wr_uart = ~tx_full, combinational.
  - Advance to the next state only on a cycle with tx_full=0. With tx_full=1, hold with wr_uart=0; there is no limit on stall length.
  - SEND_OP advances to WAIT_RES and clears the counter.
  - In all SEND states w_data = 0 when wr_uart=0, so w_data is 0 outside active writes.
- WAIT_RES:
  - rd_uart = ~rx_empty. When rx_empty=0: result <= r_data, timeout <= 0, next state DONE.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES≠0, counter == TIMEOUT_CYCLES-1 and rx_empty=1: result <= 0, timeout <= 1, next state DONE.
  - A byte arriving on the expiry cycle wins over the timeout.
- DONE: done=1 for exactly one cycle; next state IDLE. start during DONE is ignored.
- busy and done are decoded from registered state.
- start while busy=1 is ignored; no queueing. The latched operands cannot change mid-transaction.
- Nominal latency, FIFOs never full and reply available immediately:
  - start sampled at edge 0.
  - wr_uart high in cycles 1, 2, 3.
  - rd_uart in cycle 4 if rx_empty=0.
  - done in cycle 5.
  - busy back to 0 in cycle 6.
- A reset mid-transaction abandons it with no done pulse. Bytes already pushed stay in the remote FIFOs.

Test Plan:
- Nominal: a_in=8'd5, b_in=8'hFD, op_in=8'h20, one start pulse; responder model returns 8'h02 immediately -> TX sees exactly 05, FD, 20 on consecutive cycles 1-3; rd_uart in cycle 4; done in cycle 5 with result=8'h02, timeout=0.
- Backpressure: tx_full=1 for cycles 2-6 while in SEND_B -> wr_uart=0 in those cycles and no byte duplicated or lost; the FD byte is written in cycle 7, the 20 byte in cycle 8.
- Timeout: TIMEOUT_CYCLES=10, responder silent -> done exactly 10 cycles after entering WAIT_RES, plus 1 cycle for DONE; timeout=1, result=0. The following transaction with a reply clears timeout.
- Race at expiry: reply byte 8'h7F presented on the cycle the counter reaches 9 -> result=8'h7F, timeout=0.
- Stale flush / ignored start: two bytes in the RX FIFO while IDLE -> two rd_uart pulses and no done. A second start pulse during SEND_A -> only one 3-byte sequence sent.
- Reset mid-WAIT_RES: assert reset for 1 cycle -> next cycle busy=0, done never pulses, result=0, timeout=0; a new start works normally.
